// File: rtl/adder_bist.sv
// Built-in self-test controller for a WIDTH-bit ripple-carry adder: drives LFSR vectors and checks sums.
// Define ADDER_BIST_EXHAUSTIVE_EN to replace the LFSR with an up-counter that covers every input vector.
module adder_bist #(
  parameter int          WIDTH       = 4,
  parameter int          NUM_VECTORS = 10,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [15:0]      vec_count,
  output logic [1:0]       fsm_state
);

  // start is honoured only in IDLE and DONE; busy covers DRIVE and CHECK, done is DONE.
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, CHECK = 2'd2, FINISH = 2'd3} state_t;

`ifdef ADDER_BIST_EXHAUSTIVE_EN
  localparam int          TOTAL  = 1 << (2*WIDTH+1);
  localparam logic [15:0] RELOAD = 16'h0000;
`else
  localparam int          TOTAL  = NUM_VECTORS;
  localparam logic [15:0] RELOAD = SEED;
`endif
  localparam logic [15:0] TOTAL_16 = 16'(TOTAL);

  state_t        state, state_next;
  logic [15:0]   gen, gen_next;
  logic [WIDTH:0] expected;
  logic          mismatch;
  logic [15:0]   vec_next;

`ifdef ADDER_BIST_EXHAUSTIVE_EN
  assign gen_next = gen + 16'd1;
`else
  assign gen_next = {gen[14:0], gen[15] ^ gen[13] ^ gen[12] ^ gen[10]};
`endif

  assign expected = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
  assign mismatch = ({dut_carry, dut_sum} != expected);
  assign vec_next = vec_count + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   state_next = CHECK;
      CHECK:   state_next = (vec_next == TOTAL_16) ? FINISH : DRIVE;
      FINISH:  if (start) state_next = DRIVE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == DRIVE) || (state == CHECK);
    done      = (state == FINISH);
    pass      = (state == FINISH) && (err_count == 8'd0);
    fsm_state = state;
  end

  // Datapath: vector registers, generator, and result counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen       <= RELOAD;
      dut_a     <= '0;
      dut_b     <= '0;
      dut_cin   <= 1'b0;
      err_count <= 8'd0;
      vec_count <= 16'd0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            gen       <= RELOAD;
            err_count <= 8'd0;
            vec_count <= 16'd0;
          end
        end
        DRIVE: begin
          dut_a   <= gen[WIDTH-1:0];
          dut_b   <= gen[2*WIDTH-1:WIDTH];
          dut_cin <= gen[2*WIDTH];
          gen     <= gen_next;
        end
        CHECK: begin
          if (mismatch && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
          vec_count <= vec_next;
        end
        default: ;
      endcase
    end
  end

endmodule
